// File: rtl/fp_div_sqrt_arbiter.sv
// Round-robin arbiter sharing one iterative FP32 divide/sqrt unit among NUM_REQ requesters.
// Define FP_DIVSQRT_ARB_PERF_EN to add saturating grant/kill performance counters.
`timescale 1ns/1ps
module fp_div_sqrt_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_lhs,
  input  logic [NUM_REQ*32-1:0] req_rhs,
  input  logic [NUM_REQ-1:0]    req_is_divide,
  input  logic [NUM_REQ-1:0]    flush,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [31:0]           resp_result,
  output logic                  fu_req,
  output logic [31:0]           fu_lhs,
  output logic [31:0]           fu_rhs,
  output logic                  fu_is_divide,
  input  logic                  fu_finished,
  input  logic [31:0]           fu_result,
  output logic                  busy
`ifdef FP_DIVSQRT_ARB_PERF_EN
  ,
  output logic [NUM_REQ*16-1:0] perf_grant_cnt,
  output logic [15:0]           perf_kill_cnt
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    rr_nxt;
  logic [ID_W-1:0]    owner;
  logic               killed;
  logic [31:0]        op_lhs;
  logic [31:0]        op_rhs;
  logic               op_div;
  logic [31:0]        res;

  logic [NUM_REQ-1:0] eligible;
  logic               grant_vld;
  logic [ID_W-1:0]    grant_idx;
  logic [31:0]        grant_lhs;
  logic [31:0]        grant_rhs;
  logic               grant_div;
  logic               accept;
  logic               owner_flush;

  assign eligible    = req_valid & ~flush;
  assign owner_flush = flush[owner];

  // Search forward from rr_ptr with wrap; the lowest offset wins, so scan offsets downward.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_lhs = '0;
    grant_rhs = '0;
    grant_div = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (eligible[idx]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(idx);
        grant_lhs = req_lhs[32*idx +: 32];
        grant_rhs = req_rhs[32*idx +: 32];
        grant_div = req_is_divide[idx];
      end
    end
  end

  // The unit cannot abort, so nothing launches until it reports idle (also true right after reset).
  assign accept = rst_n && (state == IDLE) && fu_finished && grant_vld;
  assign rr_nxt = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept && (grant_idx == ID_W'(i));
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (fu_finished) state_nxt = (killed || owner_flush) ? IDLE : RESP;
      RESP:    if (owner_flush || resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      killed <= 1'b0;
      op_lhs <= '0;
      op_rhs <= '0;
      op_div <= 1'b0;
      res    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner  <= grant_idx;
        op_lhs <= grant_lhs;
        op_rhs <= grant_rhs;
        op_div <= grant_div;
        rr_ptr <= rr_nxt;
        killed <= 1'b0;
      end else if (((state == ISSUE) || (state == WAIT)) && owner_flush) begin
        killed <= 1'b1;
      end
      if ((state == WAIT) && fu_finished) res <= fu_result;
    end
  end

  assign fu_req       = (state == ISSUE);
  assign fu_lhs       = op_lhs;
  assign fu_rhs       = op_rhs;
  assign fu_is_divide = op_div;
  assign resp_valid   = (state == RESP);
  assign resp_id      = owner;
  assign resp_result  = res;
  assign busy         = (state != IDLE);

`ifdef FP_DIVSQRT_ARB_PERF_EN
  logic kill_evt;

  // A result is discarded either on completion of a killed op or by an owner flush while presented.
  assign kill_evt = ((state == WAIT) && fu_finished && (killed || owner_flush)) ||
                    ((state == RESP) && owner_flush);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grant_cnt <= '0;
      perf_kill_cnt  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && (perf_grant_cnt[16*i +: 16] != 16'hffff))
          perf_grant_cnt[16*i +: 16] <= perf_grant_cnt[16*i +: 16] + 16'd1;
      end
      if (kill_evt && (perf_kill_cnt != 16'hffff)) perf_kill_cnt <= perf_kill_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fp_div_sqrt_arbiter.sv
// Directed testbench for fp_div_sqrt_arbiter with a behavioural iterative div/sqrt unit.
`timescale 1ns/1ps
module tb_fp_div_sqrt_arbiter;
  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid, req_ready, req_is_divide, flush;
  logic [NUM_REQ*32-1:0] req_lhs, req_rhs;
  logic                  resp_valid, resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_result;
  logic                  fu_req;
  logic [31:0]           fu_lhs, fu_rhs;
  logic                  fu_is_divide;
  logic                  fu_finished = 1'b1;
  logic [31:0]           fu_result = 32'h0;
  logic                  busy;

  fp_div_sqrt_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_lhs(req_lhs), .req_rhs(req_rhs),
    .req_is_divide(req_is_divide), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_result(resp_result),
    .fu_req(fu_req), .fu_lhs(fu_lhs), .fu_rhs(fu_rhs), .fu_is_divide(fu_is_divide),
    .fu_finished(fu_finished), .fu_result(fu_result), .busy(busy)
  );

  // Behavioural unit: fixed latency, known answers; it is not reset by the controller.
  int          fu_lat   = 15;
  bit          fu_stall = 1'b0;
  int          fu_cnt   = 0;
  int          n_fu_req = 0;
  logic [31:0] cap_lhs  = 32'h0;
  logic [31:0] cap_rhs  = 32'h0;
  logic        cap_div  = 1'b0;

  function automatic logic [31:0] fu_compute(input logic [31:0] a, input logic [31:0] b, input logic d);
    if (d) begin
      case ({a, b})
        64'h40C00000_40000000: return 32'h40400000; // 6/2 = 3
        64'h3F800000_40000000: return 32'h3F000000; // 1/2 = 0.5
        default:               return 32'h7FC00000;
      endcase
    end else begin
      case (a)
        32'h40800000: return 32'h40000000; // sqrt 4 = 2
        32'h41100000: return 32'h40400000; // sqrt 9 = 3
        32'h41800000: return 32'h40800000; // sqrt 16 = 4
        default:      return 32'h7FC00000;
      endcase
    end
  endfunction

  always @(posedge clk) begin
    if (fu_req) begin
      fu_finished <= 1'b0;
      fu_cnt      <= fu_lat;
      cap_lhs     <= fu_lhs;
      cap_rhs     <= fu_rhs;
      cap_div     <= fu_is_divide;
      n_fu_req    <= n_fu_req + 1;
    end else if (!fu_finished && !fu_stall) begin
      if (fu_cnt <= 1) begin
        fu_finished <= 1'b1;
        fu_result   <= fu_compute(cap_lhs, cap_rhs, cap_div);
      end else begin
        fu_cnt <= fu_cnt - 1;
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wait_resp(input int max_cyc, output int cyc);
    cyc = 0;
    while (!resp_valid && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  typedef struct {
    int          id;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic        div;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[4];

  // Single-requester op from IDLE through the response handshake (resp_ready assumed 1).
  task automatic run_op(input vec_t v, input string name);
    int cyc;
    int base;
    @(negedge clk);
    req_lhs[32*v.id +: 32] = v.lhs;
    req_rhs[32*v.id +: 32] = v.rhs;
    req_is_divide[v.id]    = v.div;
    req_valid[v.id]        = 1'b1;
    #1 check({name, " ready"}, 32'(req_ready), 32'(1) << v.id);
    base = n_fu_req;
    @(negedge clk);
    req_valid[v.id] = 1'b0;
    check({name, " fu_req"}, 32'(fu_req), 32'd1);
    check({name, " fu_lhs"}, fu_lhs, v.lhs);
    check({name, " fu_div"}, 32'(fu_is_divide), 32'(v.div));
    if (v.div) check({name, " fu_rhs"}, fu_rhs, v.rhs);
    wait_resp(60, cyc);
    check({name, " resp_valid"}, 32'(resp_valid), 32'd1);
    check({name, " latency"}, 32'(cyc), 32'(fu_lat + 2));
    check({name, " resp_id"}, 32'(resp_id), 32'(v.id));
    check({name, " resp_result"}, resp_result, v.exp);
    check({name, " fu_req pulses"}, 32'(n_fu_req - base), 32'd1);
    @(negedge clk);
    check({name, " resp drop"}, 32'(resp_valid), 32'd0);
    check({name, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    int   base;
    bit   seen;
    vec_t v;

    vecs[0] = '{id: 0, lhs: 32'h40C00000, rhs: 32'h40000000, div: 1'b1, exp: 32'h40400000};
    vecs[1] = '{id: 1, lhs: 32'h40800000, rhs: 32'hDEADBEEF, div: 1'b0, exp: 32'h40000000};
    vecs[2] = '{id: 0, lhs: 32'h41100000, rhs: 32'h12345678, div: 1'b0, exp: 32'h40400000};
    vecs[3] = '{id: 1, lhs: 32'h3F800000, rhs: 32'h40000000, div: 1'b1, exp: 32'h3F000000};

    rst_n = 1'b0; req_valid = '0; req_is_divide = '0; flush = '0;
    req_lhs = '0; req_rhs = '0; resp_ready = 1'b1;
    #2;
    check("rst busy", 32'(busy), 32'd0);
    check("rst fu_req", 32'(fu_req), 32'd0);
    check("rst fu_lhs", fu_lhs, 32'd0);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst resp_result", resp_result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Fairness: both requesters hold valid for four grants.
    @(negedge clk);
    req_lhs = {32'h40800000, 32'h40C00000};
    req_rhs = {32'hDEADBEEF, 32'h40000000};
    req_is_divide = 2'b01;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_resp(80, cyc);
      check($sformatf("rr%0d valid", k), 32'(resp_valid), 32'd1);
      check($sformatf("rr%0d id", k), 32'(resp_id), 32'(k % 2));
      check($sformatf("rr%0d result", k), resp_result, (k % 2) ? 32'h40000000 : 32'h40400000);
      check($sformatf("rr%0d ready in resp", k), 32'(req_ready), 32'd0);
      if (k == 3) req_valid = 2'b00;
      @(negedge clk);
    end

    // Flush of owner 0 while the unit is running: result drained and dropped.
    req_lhs[31:0] = 32'h40C00000; req_rhs[31:0] = 32'h40000000; req_is_divide[0] = 1'b1;
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    base = n_fu_req;
    @(negedge clk);
    flush = 2'b01;
    @(negedge clk);
    flush = 2'b00;
    seen = 1'b0; cyc = 0;
    while (busy && cyc < 60) begin
      if (resp_valid) seen = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check("kill no resp", 32'(seen), 32'd0);
    check("kill idle", 32'(busy), 32'd0);
    check("kill fu done", 32'(fu_finished), 32'd1);
    check("kill one launch", 32'(n_fu_req - base), 32'd1);
    run_op(vecs[0], "after kill");

    // Flush masks a requester's grant in IDLE.
    @(negedge clk);
    req_valid = 2'b01; flush = 2'b01;
    #1 check("mask ready", 32'(req_ready), 32'd0);
    flush = 2'b00;
    #1 check("unmask ready", 32'(req_ready), 32'd1);
    req_valid = 2'b00;

    // Backpressure on req1's result while req0 waits, then flush req0 in RESP.
    @(negedge clk);
    resp_ready = 1'b0;
    req_lhs[63:32] = 32'h41800000; req_is_divide[1] = 1'b0;
    req_valid = 2'b10;
    @(negedge clk);
    req_valid = 2'b01;
    wait_resp(60, cyc);
    check("bp valid", 32'(resp_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp%0d valid", k), 32'(resp_valid), 32'd1);
      check($sformatf("bp%0d id", k), 32'(resp_id), 32'd1);
      check($sformatf("bp%0d result", k), resp_result, 32'h40800000);
      check($sformatf("bp%0d ready", k), 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    #1 check("bp next grant", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    wait_resp(60, cyc);
    check("rflush valid", 32'(resp_valid), 32'd1);
    check("rflush id", 32'(resp_id), 32'd0);
    flush = 2'b01;
    @(negedge clk);
    flush = 2'b00;
    check("rflush drop", 32'(resp_valid), 32'd0);
    check("rflush idle", 32'(busy), 32'd0);
    resp_ready = 1'b1;

    // Reset while waiting on the unit; unit keeps running independently.
    @(negedge clk);
    req_lhs[31:0] = 32'h3F800000; req_rhs[31:0] = 32'h40000000; req_is_divide[0] = 1'b1;
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    fu_stall = 1'b1;
    rst_n = 1'b0;
    #1;
    check("mrst busy", 32'(busy), 32'd0);
    check("mrst fu_lhs", fu_lhs, 32'd0);
    check("mrst fu_rhs", fu_rhs, 32'd0);
    check("mrst fu_div", 32'(fu_is_divide), 32'd0);
    check("mrst resp_result", resp_result, 32'd0);
    check("mrst resp_id", 32'(resp_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req_lhs[63:32] = 32'h40800000; req_is_divide[1] = 1'b0;
    req_valid = 2'b10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("mrst hold%0d ready", k), 32'(req_ready), 32'd0);
      check($sformatf("mrst hold%0d busy", k), 32'(busy), 32'd0);
    end
    fu_stall = 1'b0;
    cyc = 0;
    while (!busy && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("mrst grant", 32'(busy), 32'd1);
    req_valid = 2'b00;
    wait_resp(60, cyc);
    check("mrst resp valid", 32'(resp_valid), 32'd1);
    check("mrst resp id", 32'(resp_id), 32'd1);
    check("mrst resp result", resp_result, 32'h40000000);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
